ef_saradc_ctrl: RTL and testbench

Digital successive-approximation controller for a WIDTH-bit SAR ADC. It is the read-back counterpart of the 10-bit EF DAC macro.
- Drives the DAC input code and its falling-edge load strobe.
- Controls the analog sample-and-hold.
- Reads a single comparator bit and builds the conversion result MSB-first.
- Sits between the analog macros (DAC, comparator, S/H) and the bus-side ADC register wrapper.

---
 rtl/ef_saradc_pkg.sv | 26 ++
 rtl/ef_saradc_if.sv | 25 ++
 rtl/ef_saradc_cnt.sv | 26 ++
 rtl/ef_saradc_ctrl.sv | 165 ++++++++++++++++
 tb/tb_ef_saradc_ctrl.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ef_saradc_pkg.sv
// rtl/ef_saradc_pkg.sv - shared types and constants for the SAR ADC controller
package ef_saradc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SAMP,
    ST_LOAD,
    ST_SETTLE,
    ST_DECIDE,
    ST_DONE
  } state_t;

  localparam int DEF_WIDTH         = 10;
  localparam int DEF_SAMPLE_CYCLES = 4;
  localparam int DEF_SETTLE_CYCLES = 1;

  // Dwell counter width: must hold max(SAMPLE_CYCLES, SETTLE_CYCLES).
  function automatic int cnt_width(input int sample_cycles, input int settle_cycles);
    int m;
    m = (sample_cycles > settle_cycles) ? sample_cycles : settle_cycles;
    return $clog2(m + 1);
  endfunction

  localparam int DEF_CNT_W = cnt_width(DEF_SAMPLE_CYCLES, DEF_SETTLE_CYCLES);

endpackage

// File: rtl/ef_saradc_if.sv
// rtl/ef_saradc_if.sv - controller-side signal bundle between analog macros and the register wrapper
interface ef_saradc_if #(
  parameter int WIDTH = ef_saradc_pkg::DEF_WIDTH
);
  logic             en;
  logic             soc;
  logic             cont;
  logic             cmp;
  logic             sample;
  logic [WIDTH-1:0] dac_code;
  logic             dac_load;
  logic             busy;
  logic             eoc;
  logic [WIDTH-1:0] data;

  modport slave (
    input  en, soc, cont, cmp,
    output sample, dac_code, dac_load, busy, eoc, data
  );

  modport master (
    output en, soc, cont, cmp,
    input  sample, dac_code, dac_load, busy, eoc, data
  );
endinterface

// File: rtl/ef_saradc_cnt.sv
// rtl/ef_saradc_cnt.sv - loadable down-counter with zero flag for sample and settle dwell times
module ef_saradc_cnt #(
  parameter int CW = 3
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_load,
  input  logic [CW-1:0] i_val,
  output logic          o_zero
);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CW'(1);
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/ef_saradc_ctrl.sv
// rtl/ef_saradc_ctrl.sv - successive-approximation FSM and result register for a WIDTH-bit SAR ADC
module ef_saradc_ctrl
  import ef_saradc_pkg::*;
#(
  parameter int WIDTH         = DEF_WIDTH,
  parameter int SAMPLE_CYCLES = DEF_SAMPLE_CYCLES,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
  input  logic        i_clk,
  input  logic        i_rst,
  ef_saradc_if.slave  io_bus
);

  localparam int CW = cnt_width(SAMPLE_CYCLES, SETTLE_CYCLES);
  localparam int IW = $clog2(WIDTH);

  // Dwell counter runs N-1..0 so the zero flag marks the last cycle of a dwell.
  localparam logic [CW-1:0]    SAMP_LD = CW'(SAMPLE_CYCLES - 1);
  localparam logic [CW-1:0]    SETL_LD = CW'(SETTLE_CYCLES - 1);
  localparam logic [WIDTH-1:0] TOP_BIT = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [IW-1:0]    TOP_IDX = IW'(WIDTH - 1);

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_code;
  logic [WIDTH-1:0] r_data;
  logic [IW-1:0]    r_idx;
  logic             r_cmp;

  logic             w_cnt_load;
  logic [CW-1:0]    w_cnt_val;
  logic             w_cnt_zero;
  logic             w_sample;
  logic             w_dac_load;
  logic             w_busy;
  logic             w_eoc;
  logic [WIDTH-1:0] w_decide_code;

  ef_saradc_cnt #(
    .CW (CW)
  ) u_cnt (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_load (w_cnt_load),
    .i_val  (w_cnt_val),
    .o_zero (w_cnt_zero)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_cnt_load = 1'b0;
    w_cnt_val  = SAMP_LD;
    w_sample   = 1'b0;
    w_dac_load = 1'b0;
    w_busy     = 1'b1;
    w_eoc      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_busy = 1'b0;
        if (io_bus.en && io_bus.soc) begin
          w_next     = ST_SAMP;
          w_cnt_load = 1'b1;
        end
      end
      ST_SAMP: begin
        w_sample = 1'b1;
        if (w_cnt_zero) begin
          w_next = ST_LOAD;
        end
      end
      ST_LOAD: begin
        w_dac_load = 1'b1;
        w_next     = ST_SETTLE;
        w_cnt_load = 1'b1;
        w_cnt_val  = SETL_LD;
      end
      ST_SETTLE: begin
        if (w_cnt_zero) begin
          w_next = ST_DECIDE;
        end
      end
      ST_DECIDE: begin
        w_next = (r_idx == '0) ? ST_DONE : ST_LOAD;
      end
      ST_DONE: begin
        w_eoc = 1'b1;
        if (io_bus.en && io_bus.cont) begin
          w_next     = ST_SAMP;
          w_cnt_load = 1'b1;
        end else begin
          w_next = ST_IDLE;
        end
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
    // Dropping EN aborts from anywhere; the DONE cycle itself still shows EOC.
    if (!io_bus.en && r_state != ST_IDLE) begin
      w_next     = ST_IDLE;
      w_cnt_load = 1'b0;
    end
  end

  // Resolve the bit under test from the comparator and arm the next trial bit.
  always_comb begin
    w_decide_code        = r_code;
    w_decide_code[r_idx] = r_cmp;
    if (r_idx != '0) begin
      w_decide_code[r_idx - IW'(1)] = 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_code <= '0;
      r_data <= '0;
      r_idx  <= '0;
      r_cmp  <= 1'b0;
    end else begin
      r_cmp <= io_bus.cmp;
      if (w_next == ST_IDLE) begin
        r_code <= '0;
      end else begin
        case (r_state)
          ST_SAMP: begin
            if (w_cnt_zero) begin
              r_code <= TOP_BIT;
              r_idx  <= TOP_IDX;
            end
          end
          ST_DECIDE: begin
            r_code <= w_decide_code;
            if (r_idx != '0) begin
              r_idx <= r_idx - IW'(1);
            end else begin
              r_data <= w_decide_code;
            end
          end
          ST_DONE: begin
            r_code <= '0;
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign io_bus.sample   = w_sample;
  assign io_bus.dac_code = r_code;
  assign io_bus.dac_load = w_dac_load;
  assign io_bus.busy     = w_busy;
  assign io_bus.eoc      = w_eoc;
  assign io_bus.data     = r_data;

endmodule

// File: tb/tb_ef_saradc_ctrl.sv
// tb/tb_ef_saradc_ctrl.sv - scoreboard bench for ef_saradc_ctrl with an ideal DAC/comparator model
module tb_ef_saradc_ctrl;

  localparam int SD = 4;

  typedef struct {
    int dut;
    int vin;
    int cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   vin0 = 0;
  int   vin1 = 0;
  int   lat0 = 0;
  int   lat1 = 0;
  exp_t sb[$];

  ef_saradc_if #(.WIDTH(10)) if0 ();
  ef_saradc_if #(.WIDTH(8))  if1 ();

  ef_saradc_ctrl #(.WIDTH(10), .SAMPLE_CYCLES(SD), .SETTLE_CYCLES(1)) dut0 (
    .i_clk  (clk),
    .i_rst  (rst),
    .io_bus (if0)
  );

  ef_saradc_ctrl #(.WIDTH(8), .SAMPLE_CYCLES(SD), .SETTLE_CYCLES(3)) dut1 (
    .i_clk  (clk),
    .i_rst  (rst),
    .io_bus (if1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Ideal DAC latches on the falling edge of its load strobe; ideal comparator.
  always @(negedge if0.dac_load) lat0 = int'(if0.dac_code);
  always @(negedge if1.dac_load) lat1 = int'(if1.dac_code);
  assign if0.cmp = (vin0 >= lat0);
  assign if1.cmp = (vin1 >= lat1);

  logic [1:0]       m_eoc, m_busy, m_sample, m_load;
  logic [1:0][15:0] m_code, m_data;
  assign m_eoc     = {if1.eoc, if0.eoc};
  assign m_busy    = {if1.busy, if0.busy};
  assign m_sample  = {if1.sample, if0.sample};
  assign m_load    = {if1.dac_load, if0.dac_load};
  assign m_code[0] = 16'(if0.dac_code);
  assign m_code[1] = 16'(if1.dac_code);
  assign m_data[0] = 16'(if0.data);
  assign m_data[1] = 16'(if1.data);

  function automatic int wd(input int d);
    return (d == 0) ? 10 : 8;
  endfunction

  function automatic int td(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  function automatic int lat(input int d);
    return SD + wd(d) * (2 + td(d));
  endfunction

  // Trial k: the already-resolved upper k bits of vin plus the bit under test.
  function automatic int trial(input int vin, input int w, input int k);
    int keep;
    keep = (vin >> (w - k)) << (w - k);
    return keep | (1 << (w - 1 - k));
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  int samp_cnt[2];
  int load_cnt[2];
  int obs[2][16];

  always @(negedge clk) begin
    exp_t e;
    int   nbad;
    for (int d = 0; d < 2; d++) begin
      if (m_eoc[d]) begin
        if (sb.size() == 0 || sb[0].dut != d) begin
          checks++;
          errors++;
          $display("FAIL unexpected_eoc dut=%0d actual=1 expected=0 (cycle %0d)", d, cyc);
        end else begin
          e = sb.pop_front();
          chk($sformatf("data_dut%0d", d), int'(m_data[d]), e.vin);
          chk($sformatf("eoc_cycle_dut%0d", d), cyc, e.cyc);
          chk($sformatf("sample_cycles_dut%0d", d), samp_cnt[d], SD);
          chk($sformatf("dac_load_pulses_dut%0d", d), load_cnt[d], wd(d));
          nbad = 0;
          for (int k = 0; k < wd(d); k++) begin
            if (obs[d][k] != trial(e.vin, wd(d), k)) nbad++;
          end
          chk($sformatf("trial_codes_bad_dut%0d", d), nbad, 0);
        end
      end
      if (m_eoc[d] || !m_busy[d]) begin
        samp_cnt[d] = 0;
        load_cnt[d] = 0;
      end else begin
        if (m_sample[d]) samp_cnt[d]++;
        if (m_load[d]) begin
          if (load_cnt[d] < 16) obs[d][load_cnt[d]] = int'(m_code[d]);
          load_cnt[d]++;
        end
      end
    end
  end

  task automatic set_soc(input int d, input logic v);
    if (d == 0) if0.soc = v;
    else        if1.soc = v;
  endtask

  task automatic start(input int d, input int vin, input bit push);
    if (d == 0) vin0 = vin;
    else        vin1 = vin;
    if (push) sb.push_back('{d, vin, cyc + 1 + lat(d)});
    set_soc(d, 1'b1);
    @(negedge clk);
    set_soc(d, 1'b0);
  endtask

  task automatic wait_eoc(input int d, input int bound);
    int n;
    n = 0;
    while (!m_eoc[d] && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("eoc_seen_dut%0d", d), int'(m_eoc[d]), 1);
  endtask

  task automatic run_one(input int d, input int vin);
    start(d, vin, 1'b1);
    wait_eoc(d, 100);
    @(negedge clk);
    chk($sformatf("busy_after_eoc_dut%0d", d), int'(m_busy[d]), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    int base;
    int n;
    if0.en = 1'b0; if0.soc = 1'b0; if0.cont = 1'b0;
    if1.en = 1'b0; if1.soc = 1'b0; if1.cont = 1'b0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("reset_ctrl_dut%0d", d), int'({m_busy[d], m_eoc[d], m_sample[d], m_load[d]}), 0);
      chk($sformatf("reset_code_dut%0d", d), int'(m_code[d]), 0);
      chk($sformatf("reset_data_dut%0d", d), int'(m_data[d]), 0);
    end
    rst = 1'b0;
    if0.en = 1'b1;
    if1.en = 1'b1;
    @(negedge clk);

    run_one(0, 'h2A5);
    run_one(0, 'h3FF);
    run_one(0, 'h000);
    repeat (6) run_one(0, int'($urandom_range(0, 1023)));

    // Continuous mode: three back-to-back conversions, CONT dropped during the third.
    if0.cont = 1'b1;
    base = cyc + 1 + lat(0);
    start(0, 'h155, 1'b1);
    sb.push_back('{0, 'h155, base + lat(0) + 1});
    sb.push_back('{0, 'h155, base + 2 * (lat(0) + 1)});
    wait_eoc(0, 100);
    @(negedge clk);
    wait_eoc(0, 100);
    @(negedge clk);
    repeat (10) @(negedge clk);
    if0.cont = 1'b0;
    wait_eoc(0, 100);
    @(negedge clk);
    chk("busy_after_cont_stop", int'(m_busy[0]), 0);

    // SOC re-pulsed during a conversion must be ignored.
    start(0, int'($urandom_range(0, 1023)), 1'b1);
    repeat (4) @(negedge clk);
    if0.soc = 1'b1;
    @(negedge clk);
    if0.soc = 1'b0;
    repeat (14) @(negedge clk);
    if0.soc = 1'b1;
    @(negedge clk);
    if0.soc = 1'b0;
    wait_eoc(0, 100);
    repeat (40) @(negedge clk);

    // EN dropped mid-conversion: no EOC, DATA retained, DAC code cleared.
    run_one(0, 'h2A5);
    start(0, 'h0F0, 1'b0);
    repeat (13) @(negedge clk);
    if0.en = 1'b0;
    @(negedge clk);
    chk("abort_ctrl", int'({m_busy[0], m_eoc[0], m_sample[0], m_load[0]}), 0);
    chk("abort_code", int'(m_code[0]), 0);
    chk("abort_data", int'(m_data[0]), 'h2A5);
    if0.en = 1'b1;
    repeat (40) @(negedge clk);

    // Asynchronous reset during SETTLE.
    start(0, 'h1C3, 1'b0);
    n = 0;
    while (!m_load[0] && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("load_seen_before_rst", int'(m_load[0]), 1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_async_ctrl", int'({m_busy[0], m_eoc[0], m_sample[0], m_load[0]}), 0);
    chk("rst_async_code", int'(m_code[0]), 0);
    chk("rst_async_data", int'(m_data[0]), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_one(0, int'($urandom_range(0, 1023)));

    // Narrow converter with longer settle time.
    run_one(1, 'hA7);
    run_one(1, 'hFF);
    run_one(1, 'h00);
    repeat (3) run_one(1, int'($urandom_range(0, 255)));

    repeat (5) @(negedge clk);
    chk("pending_expectations", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
